// File: rtl/sfa_bif_arb.sv
// Round-robin job arbiter in front of one BRAM interface: grant, validate, launch, then track the stream beats to completion.
// ACK/BIF_EN one cycle after the grant; DONE arrives DRAIN+1 cycles after the final beat; a requester holds VALID until ACK.
module sfa_bif_arb #(
  parameter int DRAIN = 2
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        REQ0_VALID,
  input  logic [15:0] REQ0_INDEX,
  input  logic [15:0] REQ0_SIZE,
  input  logic [15:0] REQ0_STRIDE,
  input  logic        REQ0_MODE,
  output logic        REQ0_ACK,
  output logic        REQ0_DONE,
  output logic        REQ0_ERR,
  input  logic        REQ1_VALID,
  input  logic [15:0] REQ1_INDEX,
  input  logic [15:0] REQ1_SIZE,
  input  logic [15:0] REQ1_STRIDE,
  input  logic        REQ1_MODE,
  output logic        REQ1_ACK,
  output logic        REQ1_DONE,
  output logic        REQ1_ERR,
  output logic [15:0] INDEX,
  output logic [15:0] SIZE,
  output logic [15:0] STRIDE,
  output logic        MODE,
  output logic        BIF_EN,
  input  logic        RD_TVALID,
  input  logic        RD_TREADY,
  input  logic        WR_TVALID,
  input  logic        WR_TREADY,
  output logic        BUSY,
  output logic        GNT_ID
);

  localparam int DW = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_LAUNCH, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic            last_q, gnt_q;
  logic            err_q, err_d;
  logic [17:0]     shadow_q, shadow_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            sel_vld, sel_id;
  logic [19:0]     limit, reach;
  logic [17:0]     step, shadow_inc;
  logic            beat, desc_bad, launch_ok;

  assign sel_vld    = REQ0_VALID | REQ1_VALID;
  assign sel_id     = (REQ0_VALID & REQ1_VALID) ? ~last_q : REQ1_VALID;

  // Wide enough that the wrap check itself can never wrap.
  assign limit      = {4'd0, INDEX} + {2'd0, SIZE, 2'd0};
  assign reach      = limit + {2'd0, STRIDE, 2'd0};
  assign desc_bad   = (STRIDE == 16'd0) || (reach > 20'h10000);
  assign launch_ok  = !desc_bad && (SIZE != 16'd0);
  assign step       = {STRIDE, 2'd0};
  assign shadow_inc = shadow_q + step;
  assign beat       = MODE ? (WR_TVALID & WR_TREADY) : (RD_TVALID & RD_TREADY);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      err_q    <= 1'b0;
      shadow_q <= '0;
      drain_q  <= '0;
      INDEX    <= '0;
      SIZE     <= '0;
      STRIDE   <= '0;
      MODE     <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      drain_q  <= drain_d;
      if (state_q == ST_IDLE && sel_vld) begin
        gnt_q  <= sel_id;
        last_q <= sel_id;
        INDEX  <= sel_id ? REQ1_INDEX  : REQ0_INDEX;
        SIZE   <= sel_id ? REQ1_SIZE   : REQ0_SIZE;
        STRIDE <= sel_id ? REQ1_STRIDE : REQ0_STRIDE;
        MODE   <= sel_id ? REQ1_MODE   : REQ0_MODE;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    shadow_d = shadow_q;
    drain_d  = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_vld) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        err_d = desc_bad;
        if (launch_ok) begin
          shadow_d = {2'd0, INDEX};
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_DONE;
        end
      end
      ST_RUN: begin
        if (beat) begin
          shadow_d = shadow_inc;
          if ({2'd0, shadow_inc} >= limit) begin
            if (DRAIN == 0) begin
              state_d = ST_DONE;
            end else begin
              drain_d = DW'(DRAIN);
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q <= DW'(1)) state_d = ST_DONE;
        else                   drain_d = drain_q - DW'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign BUSY      = (state_q != ST_IDLE);
  assign GNT_ID    = gnt_q;
  assign BIF_EN    = (state_q == ST_LAUNCH) && launch_ok;
  assign REQ0_ACK  = (state_q == ST_LAUNCH) && !gnt_q;
  assign REQ1_ACK  = (state_q == ST_LAUNCH) &&  gnt_q;
  assign REQ0_DONE = (state_q == ST_DONE)   && !gnt_q;
  assign REQ1_DONE = (state_q == ST_DONE)   &&  gnt_q;
  assign REQ0_ERR  = REQ0_DONE && err_q;
  assign REQ1_ERR  = REQ1_DONE && err_q;

endmodule

// File: tb/tb_sfa_bif_arb.sv
// Randomized scoreboard bench for sfa_bif_arb: stimulus pushes expected jobs, a negedge monitor checks them.
`timescale 1ns/100ps
module tb_sfa_bif_arb;

  localparam int DRAIN = 2;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [15:0] REQ0_INDEX = '0, REQ0_SIZE = '0, REQ0_STRIDE = '0;
  logic [15:0] REQ1_INDEX = '0, REQ1_SIZE = '0, REQ1_STRIDE = '0;
  logic        REQ0_MODE = 1'b0, REQ1_MODE = 1'b0;
  logic        REQ0_ACK, REQ0_DONE, REQ0_ERR, REQ1_ACK, REQ1_DONE, REQ1_ERR;
  logic [15:0] INDEX, SIZE, STRIDE;
  logic        MODE, BIF_EN, BUSY, GNT_ID;
  logic        RD_TVALID = 1'b0, RD_TREADY = 1'b0, WR_TVALID = 1'b0, WR_TREADY = 1'b0;

  sfa_bif_arb #(.DRAIN(DRAIN)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .REQ0_VALID(REQ0_VALID), .REQ0_INDEX(REQ0_INDEX), .REQ0_SIZE(REQ0_SIZE),
    .REQ0_STRIDE(REQ0_STRIDE), .REQ0_MODE(REQ0_MODE),
    .REQ0_ACK(REQ0_ACK), .REQ0_DONE(REQ0_DONE), .REQ0_ERR(REQ0_ERR),
    .REQ1_VALID(REQ1_VALID), .REQ1_INDEX(REQ1_INDEX), .REQ1_SIZE(REQ1_SIZE),
    .REQ1_STRIDE(REQ1_STRIDE), .REQ1_MODE(REQ1_MODE),
    .REQ1_ACK(REQ1_ACK), .REQ1_DONE(REQ1_DONE), .REQ1_ERR(REQ1_ERR),
    .INDEX(INDEX), .SIZE(SIZE), .STRIDE(STRIDE), .MODE(MODE), .BIF_EN(BIF_EN),
    .RD_TVALID(RD_TVALID), .RD_TREADY(RD_TREADY),
    .WR_TVALID(WR_TVALID), .WR_TREADY(WR_TREADY),
    .BUSY(BUSY), .GNT_ID(GNT_ID)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    int id; bit err; bit run;
    int index; int size; int stride; int mode; int nbeats;
  } job_t;

  job_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: peeks the expected job on ACK, pops and scores it on DONE.
  int   cyc = 0;
  bit   in_job = 0;
  job_t cur;
  int   ack_cyc, last_b, beats, en_cnt;
  bit   cfg_bad, busy_bad;

  always @(negedge ACLK) begin
    cyc++;
    if (!ARESETN) begin
      in_job = 0;
    end else if (REQ0_ACK || REQ1_ACK) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 1, 0);
      end else begin
        cur = exp_q[0];
        check("ack_id", {REQ1_ACK, REQ0_ACK}, cur.id ? 2 : 1);
        check("gnt_id", GNT_ID, cur.id);
        check("cfg_launch", {INDEX, SIZE, STRIDE, MODE},
              {16'(cur.index), 16'(cur.size), 16'(cur.stride), 1'(cur.mode)});
        check("bif_en_launch", BIF_EN, cur.run);
        in_job = 1; ack_cyc = cyc; last_b = cyc; beats = 0; en_cnt = 0;
        cfg_bad = 0; busy_bad = 0;
      end
    end else if (in_job) begin
      if (BIF_EN) en_cnt++;
      if (!BUSY) busy_bad = 1;
      if ({INDEX, SIZE, STRIDE, MODE} !==
          {16'(cur.index), 16'(cur.size), 16'(cur.stride), 1'(cur.mode)}) cfg_bad = 1;
      if (REQ0_DONE || REQ1_DONE) begin
        check("done_id", {REQ1_DONE, REQ0_DONE}, cur.id ? 2 : 1);
        check("err", {REQ1_ERR, REQ0_ERR}, cur.err ? (cur.id ? 2 : 1) : 0);
        check("beats", beats, cur.nbeats);
        check("done_latency", cyc - (cur.run ? last_b : ack_cyc), cur.run ? DRAIN + 1 : 1);
        check("bif_en_extra", en_cnt, 0);
        check("cfg_stable", cfg_bad, 0);
        check("busy_held", busy_bad, 0);
        check("gnt_at_done", GNT_ID, cur.id);
        void'(exp_q.pop_front());
        in_job = 0;
      end else if (cur.mode != 0 ? (WR_TVALID && WR_TREADY) : (RD_TVALID && RD_TREADY)) begin
        beats++;
        last_b = cyc;
      end
    end else if (REQ0_DONE || REQ1_DONE) begin
      check("done_unexpected", 1, 0);
    end
  end

  // Reference model state: who is posted, and the round-robin pointer.
  bit m_last = 1;
  bit pend[2];
  int d_idx[2], d_sz[2], d_st[2], d_md[2];

  task automatic post(input int id, input int idx, input int sz, input int st, input int md);
    d_idx[id] = idx; d_sz[id] = sz; d_st[id] = st; d_md[id] = md; pend[id] = 1;
    if (id == 0) begin
      REQ0_INDEX = 16'(idx); REQ0_SIZE = 16'(sz); REQ0_STRIDE = 16'(st);
      REQ0_MODE = 1'(md); REQ0_VALID = 1'b1;
    end else begin
      REQ1_INDEX = 16'(idx); REQ1_SIZE = 16'(sz); REQ1_STRIDE = 16'(st);
      REQ1_MODE = 1'(md); REQ1_VALID = 1'b1;
    end
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    RD_TVALID = 1'b0; RD_TREADY = 1'b0; WR_TVALID = 1'b0; WR_TREADY = 1'b0;
    pend[0] = 0; pend[1] = 0; m_last = 1;
    exp_q.delete();
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  task automatic drive_beats(input int md, input int n, input int duty);
    int got = 0;
    int g = 0;
    bit v, r;
    while (got < n && g < 400) begin
      @(posedge ACLK); #1;
      g++;
      v = ($urandom_range(0, 3) != 0);
      r = duty ? (g % 3 == 0) : 1'b1;
      if (md != 0) begin
        WR_TVALID = v; WR_TREADY = r;
        RD_TVALID = 1'($urandom_range(0, 1)); RD_TREADY = 1'($urandom_range(0, 1));
      end else begin
        RD_TVALID = v; RD_TREADY = r;
        WR_TVALID = 1'($urandom_range(0, 1)); WR_TREADY = 1'($urandom_range(0, 1));
      end
      if (v && r) got++;
    end
    @(posedge ACLK); #1;
    RD_TVALID = 1'b0; RD_TREADY = 1'b0; WR_TVALID = 1'b0; WR_TREADY = 1'b0;
  endtask

  task automatic serve(input int duty, input int stop_after);
    int   g, n;
    job_t j;
    g = (pend[0] && pend[1]) ? (m_last ? 0 : 1) : (pend[1] ? 1 : 0);
    m_last = g[0];
    j.id = g; j.index = d_idx[g]; j.size = d_sz[g]; j.stride = d_st[g]; j.mode = d_md[g];
    j.err = (j.stride == 0) || (j.index + 4 * j.size + 4 * j.stride > 65536);
    j.run = !j.err && (j.size != 0);
    j.nbeats = j.run ? (j.size + j.stride - 1) / j.stride : 0;
    exp_q.push_back(j);
    n = 0;
    do begin @(negedge ACLK); n++; end while (!(REQ0_ACK || REQ1_ACK) && n < 10);
    if (!(REQ0_ACK || REQ1_ACK)) begin
      check("ack_timeout", 1, 0);
      do_reset();
      return;
    end
    if (g == 0) REQ0_VALID = 1'b0; else REQ1_VALID = 1'b0;
    pend[g] = 0;
    if (stop_after >= 0) begin
      drive_beats(j.mode, stop_after, duty);
      #2 ARESETN = 1'b0;
      #1;
      check("async_reset_outputs",
            {INDEX, SIZE, STRIDE, MODE, BIF_EN, REQ0_ACK, REQ1_ACK, REQ0_DONE, REQ1_DONE,
             REQ0_ERR, REQ1_ERR, BUSY, GNT_ID}, 0);
      do_reset();
      return;
    end
    if (j.run) drive_beats(j.mode, j.nbeats, duty);
    n = 0;
    while (!(REQ0_DONE || REQ1_DONE) && n < 60) begin @(negedge ACLK); n++; end
    if (!(REQ0_DONE || REQ1_DONE)) begin
      check("done_timeout", 1, 0);
      do_reset();
    end
  endtask

  task automatic post_random(input int id);
    int idx;
    idx = ($urandom_range(0, 9) == 0) ? $urandom_range(65400, 65535) : $urandom_range(0, 4000);
    post(id, idx, $urandom_range(0, 10), $urandom_range(0, 4), $urandom_range(0, 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_outputs",
          {INDEX, SIZE, STRIDE, MODE, BIF_EN, REQ0_ACK, REQ1_ACK, REQ0_DONE, REQ1_DONE,
           REQ0_ERR, REQ1_ERR, BUSY, GNT_ID}, 0);
    // Contention from reset: read job on 0, strided write on 1, then 0 again.
    post(0, 'h10, 4, 1, 0);
    post(1, 'h100, 5, 2, 1);
    @(posedge ACLK); #1 ARESETN = 1'b1;
    serve(0, -1);
    serve(0, -1);
    post(0, 'h40, 3, 1, 1);
    serve(0, -1);
    // Rejects and empty job.
    post(1, 'h20, 4, 0, 0);       serve(0, -1);
    post(0, 'hFFF0, 4, 1, 0);     serve(0, -1);
    post(1, 'h30, 0, 1, 0);       serve(0, -1);
    // Backpressured read.
    post(0, 'h80, 6, 1, 0);       serve(1, -1);
    // Reset after 2 of 8 beats, then a clean job.
    post(1, 'h200, 8, 1, 0);      serve(0, 2);
    post(0, 'h300, 4, 2, 1);      serve(0, -1);
    for (int i = 0; i < 40; i++) begin
      for (int id = 0; id < 2; id++)
        if (!pend[id] && $urandom_range(0, 1) == 1) post_random(id);
      if (!pend[0] && !pend[1]) post_random($urandom_range(0, 1));
      serve($urandom_range(0, 1), -1);
    end
    while (pend[0] || pend[1]) serve(0, -1);
    repeat (4) @(posedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
